// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one decryption round per clock over a 128-bit state register.
// Round keys are fetched from an external expanded-key store addressed by rk_idx.
module aes_inv_cipher_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_block,
    output logic [3:0]   rk_idx,
    input  logic [0:127] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_block,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t       state, state_nxt;
    logic [3:0]   cnt, cnt_nxt;
    logic [0:127] st, st_nxt;
    logic [0:127] round_out;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[1:0], s[7:2]} ^ {s[4:0], s[7:5]} ^ {s[6:0], s[7]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // ShiftRows with direction select; dec=1 rotates each row right by its row index.
    function automatic logic [0:127] shift_rows(input logic [0:127] blk, input logic dec);
        logic [0:127] o;
        int           sc;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sc = dec ? (c - r + 4) % 4 : (c + r) % 4;
                o[8*(4*c+r) +: 8] = blk[8*(4*sc+r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] inv_sub_bytes(input logic [0:127] blk);
        logic [0:127] o;
        o = '0;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = inv_sbox(blk[8*k +: 8]);
        return o;
    endfunction

    function automatic logic [0:127] inv_mix_columns(input logic [0:127] blk);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = blk[32*c +: 8];
            a1 = blk[32*c+8 +: 8];
            a2 = blk[32*c+16 +: 8];
            a3 = blk[32*c+24 +: 8];
            o[32*c +: 8]    = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[32*c+8 +: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Round datapath: state register -> InvShiftRows -> InvSubBytes -> key XOR -> InvMixColumns.
    always_comb begin
        round_out = inv_sub_bytes(shift_rows(st, 1'b1)) ^ rk_data;
        if (cnt != 4'd0) round_out = inv_mix_columns(round_out);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            st    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            st    <= st_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        st_nxt    = st;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rk_idx    = 4'(NR);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_nxt    = in_block ^ rk_data;
                    cnt_nxt   = 4'(NR - 1);
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                busy   = 1'b1;
                rk_idx = cnt;
                st_nxt = round_out;
                if (cnt == 4'd0) state_nxt = DONE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_block = st;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: table-driven AES decryption model with a per-cycle transaction monitor,
// directed FIPS-197 vectors, backpressure, back-to-back, mid-round reset and a random regression.
module tb_aes_inv_cipher_iter;

    localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [0:127] in_block, rk_data, out_block;
    logic [3:0]   rk_idx;

    logic [0:127] ks [0:10];
    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rk_data = (rk_idx <= 4'd10) ? ks[rk_idx] : '0;

    aes_inv_cipher_iter #(.NR(10)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .rk_idx(rk_idx), .rk_data(rk_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int k);
        return (a << k) | (a >> (8 - k));
    endfunction

    // Forward S-box from brute-force inverses, inverse S-box by table inversion.
    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    task automatic set_key(input logic [0:127] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [0:127] ref_decrypt(input logic [0:127] ct);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   a0, a1, a2, a3;
        logic [0:127] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = ct[8*(4*c+r) +: 8] ^ ks[10][8*(4*c+r) +: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = isbox[s[r][(c - r + 4) % 4]] ^ ks[rnd][8*(4*c+r) +: 8];
            for (int c = 0; c < 4; c++) begin
                a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
                if (rnd > 0) begin
                    s[0][c] = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
                    s[1][c] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
                    s[2][c] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
                    s[3][c] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
                end else begin
                    s[0][c] = a0; s[1][c] = a1; s[2][c] = a2; s[3][c] = a3;
                end
            end
        end
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(4*c+r) +: 8] = s[r][c];
        return o;
    endfunction

    // ---------------- per-cycle monitor (negedge) ----------------
    int           cyc = 0;
    int           m_left = 0;
    bit           m_pend = 0;
    bit           m_known = 0;
    bit           m_zero = 0;
    logic [0:127] m_pt = '0;
    int           m_acc = 0, m_out = 0, m_abort = 0;
    int           acc_cyc [$];

    always @(negedge clk) begin
        cyc++;
        if (m_known) begin
            if (m_pend) begin
                chk("done_out_valid", 128'(out_valid), 128'd1);
                chk("done_in_ready", 128'(in_ready), 128'd0);
                chk("done_busy", 128'(busy), 128'd0);
                chk("plaintext", out_block, m_pt);
            end else if (m_left > 0) begin
                chk("round_busy", 128'(busy), 128'd1);
                chk("round_in_ready", 128'(in_ready), 128'd0);
                chk("round_out_valid", 128'(out_valid), 128'd0);
                chk("round_rk_idx", 128'(rk_idx), 128'(m_left - 1));
            end else begin
                chk("idle_in_ready", 128'(in_ready), 128'd1);
                chk("idle_busy", 128'(busy), 128'd0);
                chk("idle_out_valid", 128'(out_valid), 128'd0);
                chk("idle_rk_idx", 128'(rk_idx), 128'd10);
                if (m_zero) chk("idle_out_block_zero", out_block, 128'd0);
            end
        end
        if (rst) begin
            if (m_left > 0 || m_pend) m_abort++;
            m_left  = 0;
            m_pend  = 0;
            m_known = 1;
            m_zero  = 1;
        end else if (m_known) begin
            if (m_pend) begin
                if (out_ready) begin
                    m_pend = 0;
                    m_out++;
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_pend = 1;
            end else if (in_valid) begin
                m_left = 10;
                m_pt   = ref_decrypt(in_block);
                m_zero = 0;
                m_acc++;
                acc_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- drivers (active at posedge + 1) ----------------
    task automatic send(input logic [0:127] ct);
        bit ok;
        ok       = 0;
        in_block = ct;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("accept_within_bound", 128'(ok), 128'd1);
    endtask

    task automatic wait_out(input bit stall, output logic [0:127] got);
        bit ok;
        ok  = 0;
        got = '0;
        for (int i = 0; i < 300 && !ok; i++) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                ok  = 1;
                got = out_block;
            end
            @(posedge clk); #1;
        end
        chk("output_within_bound", 128'(ok), 128'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:127] got, key, ct;
        bit           ok;
        int           d;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_block  = '0;
        out_ready = 1'b0;

        build_tables();
        set_key(C1_KEY);
        chk("pin_sbox_00", 128'(sbox[0]), 128'h63);
        chk("pin_sbox_53", 128'(sbox[8'h53]), 128'hed);
        chk("pin_isbox_00", 128'(isbox[0]), 128'h52);
        chk("pin_ks1", ks[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        chk("pin_ks10", ks[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("pin_model_c1", ref_decrypt(C1_CT), C1_PT);

        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_rk_idx", 128'(rk_idx), 128'd10);
        chk("rst_out_block", out_block, 128'd0);
        rst = 1'b0;

        // FIPS-197 C.1 with round-key trace and latency
        in_block  = C1_CT;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk("trace_accept_rk10", 128'(rk_idx), 128'd10);
        for (int k = 9; k >= 0; k--) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("trace_rk_idx", 128'(rk_idx), 128'(k));
            chk("c1_not_early", 128'(out_valid), 128'd0);
        end
        @(posedge clk); #1;
        chk("c1_out_valid_at_10", 128'(out_valid), 128'd1);
        chk("c1_plaintext", out_block, C1_PT);
        @(posedge clk); #1;
        chk("trace_back_to_rk10", 128'(rk_idx), 128'd10);
        chk("c1_in_ready_after", 128'(in_ready), 128'd1);

        // Backpressure: 20 stalled cycles in DONE with in_valid asserted
        out_ready = 1'b0;
        send(C1_CT);
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (out_valid) ok = 1;
            else begin @(posedge clk); #1; end
        end
        chk("bp_reach_done", 128'(ok), 128'd1);
        in_block = ~C1_PT;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_out_block", out_block, C1_PT);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released_idle", 128'(in_ready), 128'd1);
        chk("bp_released_valid", 128'(out_valid), 128'd0);

        // Back-to-back with in_valid and out_ready held high
        in_block = C1_CT;
        in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        chk("b2b_first_accept", 128'(ok), 128'd1);
        in_block = ~C1_CT;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        chk("b2b_second_accept", 128'(ok), 128'd1);
        in_valid = 1'b0;
        wait_out(1'b0, got);
        chk("b2b_second_plain", got, ref_decrypt(~C1_CT));
        d = acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2];
        chk("b2b_spacing", 128'(d), 128'd12);

        // Reset while the round counter is 5
        send(C1_CT);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (busy && rk_idx == 4'd5) ok = 1;
            else begin @(posedge clk); #1; end
        end
        chk("mid_reach_round5", 128'(ok), 128'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
        chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_out_block", out_block, 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        send(C1_CT);
        wait_out(1'b0, got);
        chk("mid_rst_recover", got, C1_PT);

        // Random regression with output stalls
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
            set_key(key);
            send(ct);
            wait_out(1'b1, got);
            chk("rand_plain", got, ref_decrypt(ct));
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        chk("accept_count", 128'(m_acc), 128'd1006);
        chk("abort_count", 128'(m_abort), 128'd1);
        chk("no_drop_or_dup", 128'(m_out), 128'(m_acc - m_abort));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES-128 inverse cipher core: accepts one 128-bit ciphertext block, performs the ten AES decryption rounds at one round per clock, and returns the plaintext block. It is the decryption counterpart of the encryption round datapath. It reuses the team's ShiftRows block in its decryption configuration. Round keys come from an external expanded-key store that this block indexes.

## Interface

- Parameters
  - `NR`, default 10: number of rounds; only 10 (AES-128) is supported.
- Ports
  - `clk`, input, 1: sole clock; all state updates on rising edge.
  - `rst`, input, 1: synchronous, active-high reset.
  - `in_valid`, input, 1: ciphertext block offered.
  - `in_ready`, output, 1: core can accept a block.
  - `in_block`, input, 128 (`[0:127]`): ciphertext. Byte k is bits `[8k:8k+7]`. Column-major: bytes 0-3 form column 0.
  - `rk_idx`, output, 4: index (0..10) of the round key required this cycle.
  - `rk_data`, input, 128 (`[0:127]`): round key `rk_idx`, combinationally valid in the same cycle; byte order matches `in_block`.
  - `out_valid`, output, 1: plaintext available.
  - `out_ready`, input, 1: consumer accepts plaintext.
  - `out_block`, output, 128 (`[0:127]`): plaintext.
  - `busy`, output, 1: high in ROUND state.

## Operation

- FSM states: IDLE, ROUND, DONE.
- IDLE
  - `in_ready`=1 and `rk_idx`=10.
  - On `in_valid`: state register <= `in_block` ^ `rk_data`, round counter <= 9, go to ROUND.
- ROUND
  - `rk_idx` = round counter.
  - Combinational path: InvShiftRows (ShiftRows, decryption configuration), then InvSubBytes (16 inverse S-box lookups), then XOR `rk_data`.
  - While counter ≥ 1, apply InvMixColumns after the XOR. The coefficients {0e,0b,0d,09} apply per column over GF(2^8) with polynomial 0x11B.
  - Counter = 0: no InvMixColumns. Register the result into the state register and go to DONE.
  - Otherwise decrement the counter.
- DONE
  - `out_valid`=1 and `out_block` = state register.
  - On `out_ready`, go to IDLE.
  - `out_block` is stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` is high only in IDLE; blocks are never accepted in ROUND or DONE.
- `in_block` and `rk_data` are sampled only on the cycles listed above. Changes on other cycles have no effect.
- In IDLE and ROUND, `out_block` keeps the state register value but is don't-care to consumers.
- Round key usage order is 10, 9, 8, …, 0, each exactly once per block.

## Timing

- Reset (`rst`=1 at an edge) forces:
  - FSM to IDLE, counter to 0, state register to 0.
  - `in_ready`=1 in the following cycle; `out_valid`=0, `busy`=0, `rk_idx`=10, `out_block`=0.
- Reset takes priority over every other event, including mid-ROUND and in DONE. An in-flight block is discarded with no output.
- Latency:
  - Handshake accepted at edge E0.
  - Rounds register at edges E1..E10.
  - `out_valid` rises after E10: 10 cycles from acceptance to first `out_valid` cycle.
- Throughput: a new block can be accepted the cycle after the DONE handshake. With `out_ready` held high, the minimum spacing is 12 cycles between accepts.
- `out_valid` and `out_ready` both high at an edge completes the transfer; `in_ready` is high in the next cycle.
- `in_valid` held high during ROUND/DONE is ignored; it is accepted on the first IDLE cycle.
- `rk_idx` is a registered-state decode and glitch-free relative to the clock; the key store may be a combinational array.
- Critical path: state register → InvShiftRows → inverse S-box → XOR → InvMixColumns → state register. One round per cycle is required; no multicycle paths.

## Test plan

- FIPS-197 C.1 vector:
  - Stimulus: bench supplies the key schedule for key 000102030405060708090a0b0c0d0e0f, `in_block` 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: `out_block` 00112233445566778899aabbccddeeff, with `out_valid` exactly 10 cycles after accept.
- Round-key index trace:
  - Stimulus: same vector.
  - Required: `rk_idx` sequence 10 (accept cycle), 9, 8, …, 0; then 10 again after return to IDLE.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 20 cycles in DONE.
  - Required: `out_valid`=1 and `out_block` constant throughout; `in_ready`=0 despite `in_valid`=1; completes on `out_ready`.
- Back-to-back:
  - Stimulus: two blocks with `in_valid` and `out_ready` held high, second block = FIPS-197 C.1 ciphertext ^ all-ones.
  - Required: accepts 12 cycles apart; both plaintexts match the software reference model.
- Reset mid-operation:
  - Stimulus: assert `rst` for one cycle during round counter = 5.
  - Required: next cycle IDLE, `out_valid`=0, `out_block`=0, `in_ready`=1; a fresh C.1 block afterwards decrypts correctly.
- Random regression: 1000 random key/ciphertext pairs against the reference model, with random `out_ready` stalls. Required: zero mismatches and no dropped or duplicated outputs.
